// File: rtl/pio_master.sv
// pio_master: turns local commands into single Avalon-MM GPIO reads/writes.
// Define PIO_MASTER_POLL_EN to add a background poll of GPIO word 2 every POLL_PERIOD idle cycles.
module pio_master #(
    parameter int unsigned POLL_PERIOD = 1024
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    output logic [2:0]  avm_gpio_address,
    output logic [31:0] avm_gpio_writedata,
    input  logic [31:0] avm_gpio_readdata,
    output logic [3:0]  avm_gpio_byteenable,
    output logic        avm_gpio_write,
    output logic        avm_gpio_read,
    input  logic        avm_gpio_waitrequest,
    input  logic        coe_cmd_valid,
    output logic        coe_cmd_ready,
    input  logic        coe_cmd_write,
    input  logic [2:0]  coe_cmd_address,
    input  logic [31:0] coe_cmd_wdata,
    output logic        coe_rsp_valid,
    output logic [31:0] coe_rsp_rdata,
    output logic [31:0] coe_poll_data,
    output logic        coe_poll_change
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RLAT,
        S_POLL,
        S_PLAT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_readyEn;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_rspValid;
    logic [31:0] r_rspRdata;
    logic        w_accept;
    logic        w_pollDue;

    // r_readyEn keeps cmd_ready low while in reset and for the first edge after release.
    assign coe_cmd_ready       = r_readyEn && (r_state == S_IDLE);
    assign w_accept            = coe_cmd_valid && coe_cmd_ready;
    assign avm_gpio_write      = (r_state == S_WRITE);
    assign avm_gpio_read       = (r_state == S_READ) || (r_state == S_POLL);
    assign avm_gpio_byteenable = (avm_gpio_write || avm_gpio_read) ? 4'hF : 4'h0;
    assign avm_gpio_address    = r_addr;
    assign avm_gpio_writedata  = r_wdata;
    assign coe_rsp_valid       = r_rspValid;
    assign coe_rsp_rdata       = r_rspRdata;

`ifdef PIO_MASTER_POLL_EN
    localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

    logic [15:0] r_pollCnt;
    logic [31:0] r_pollData;
    logic        r_pollChange;

    // A command offered in the terminal-count cycle wins; the saturated count fires the poll later.
    assign w_pollDue       = coe_cmd_ready && !coe_cmd_valid && (r_pollCnt == POLL_LAST);
    assign coe_poll_data   = r_pollData;
    assign coe_poll_change = r_pollChange;

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_pollCnt <= '0;
        end else if (w_pollDue) begin
            r_pollCnt <= '0;
        end else if (coe_cmd_ready && (r_pollCnt != POLL_LAST)) begin
            r_pollCnt <= r_pollCnt + 16'd1;
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_pollData   <= '0;
            r_pollChange <= 1'b0;
        end else begin
            r_pollChange <= 1'b0;
            if (r_state == S_PLAT) begin
                r_pollData   <= avm_gpio_readdata;
                r_pollChange <= (avm_gpio_readdata != r_pollData);
            end
        end
    end
`else
    logic w_unusedPeriod;

    assign w_unusedPeriod  = (POLL_PERIOD > 0);
    assign w_pollDue       = 1'b0;
    assign coe_poll_data   = '0;
    assign coe_poll_change = 1'b0;
`endif

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = coe_cmd_write ? S_WRITE : S_READ;
                end else if (w_pollDue) begin
                    w_nextState = S_POLL;
                end
            end
            S_WRITE: if (!avm_gpio_waitrequest) w_nextState = S_IDLE;
            S_READ:  if (!avm_gpio_waitrequest) w_nextState = S_RLAT;
            S_RLAT:  w_nextState = S_IDLE;
`ifdef PIO_MASTER_POLL_EN
            S_POLL:  if (!avm_gpio_waitrequest) w_nextState = S_PLAT;
            S_PLAT:  w_nextState = S_IDLE;
`endif
            default: w_nextState = S_IDLE;
        endcase
    end

    // Address/writedata are captured once per transaction and held afterwards.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_readyEn  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_readyEn  <= 1'b1;
            r_rspValid <= ((r_state == S_WRITE) && !avm_gpio_waitrequest) || (r_state == S_RLAT);
            if (w_accept) begin
                r_addr <= coe_cmd_address;
                if (coe_cmd_write) begin
                    r_wdata <= coe_cmd_wdata;
                end
            end else if (w_pollDue) begin
                r_addr <= 3'd2;
            end
            if (r_state == S_RLAT) begin
                r_rspRdata <= avm_gpio_readdata;
            end
        end
    end

endmodule

// File: tb/tb_pio_master.sv
// tb_pio_master: directed checks with literal expectations plus a randomized run
// compared every cycle against a transaction-level model of the master.
module tb_pio_master;

    localparam int PERIOD = 8;
`ifdef PIO_MASTER_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  avm_gpio_address;
    logic [31:0] avm_gpio_writedata;
    logic [31:0] avm_gpio_readdata;
    logic [3:0]  avm_gpio_byteenable;
    logic        avm_gpio_write;
    logic        avm_gpio_read;
    logic        avm_gpio_waitrequest;
    logic        coe_cmd_valid;
    logic        coe_cmd_ready;
    logic        coe_cmd_write;
    logic [2:0]  coe_cmd_address;
    logic [31:0] coe_cmd_wdata;
    logic        coe_rsp_valid;
    logic [31:0] coe_rsp_rdata;
    logic [31:0] coe_poll_data;
    logic        coe_poll_change;

    int total = 0;
    int bad   = 0;

    pio_master #(.POLL_PERIOD(PERIOD)) dut (
        .csi_MCLK_clk        (clk),
        .rsi_MRST_reset_n    (rst_n),
        .avm_gpio_address    (avm_gpio_address),
        .avm_gpio_writedata  (avm_gpio_writedata),
        .avm_gpio_readdata   (avm_gpio_readdata),
        .avm_gpio_byteenable (avm_gpio_byteenable),
        .avm_gpio_write      (avm_gpio_write),
        .avm_gpio_read       (avm_gpio_read),
        .avm_gpio_waitrequest(avm_gpio_waitrequest),
        .coe_cmd_valid       (coe_cmd_valid),
        .coe_cmd_ready       (coe_cmd_ready),
        .coe_cmd_write       (coe_cmd_write),
        .coe_cmd_address     (coe_cmd_address),
        .coe_cmd_wdata       (coe_cmd_wdata),
        .coe_rsp_valid       (coe_rsp_valid),
        .coe_rsp_rdata       (coe_rsp_rdata),
        .coe_poll_data       (coe_poll_data),
        .coe_poll_change     (coe_poll_change)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'd0, actual}, {31'd0, expected});
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [2:0] addr,
                                 input logic [31:0] wdata, input logic waitReq, input logic [31:0] rdata);
        coe_cmd_valid        = valid;
        coe_cmd_write        = wr;
        coe_cmd_address      = addr;
        coe_cmd_wdata        = wdata;
        avm_gpio_waitrequest = waitReq;
        avm_gpio_readdata    = rdata;
    endtask

    // Transaction-level model: one outstanding transfer, described by what it is and
    // whether its request phase has been granted yet.
    logic        mReadyEn, mBusy, mIsWrite, mIsPoll, mDataPhase;
    logic        mRsp, mChange;
    logic [2:0]  mAddr;
    logic [31:0] mWdata, mRdata, mPollData;
    int          mIdleCnt;

    task automatic modelReset();
        mReadyEn = 0; mBusy = 0; mIsWrite = 0; mIsPoll = 0; mDataPhase = 0;
        mRsp = 0; mChange = 0; mAddr = 0; mWdata = 0; mRdata = 0; mPollData = 0;
        mIdleCnt = 0;
    endtask

    task automatic modelStep();
        logic newRsp;
        logic newChange;
        newRsp = 0;
        newChange = 0;
        if (mBusy && !mDataPhase) begin
            if (!avm_gpio_waitrequest) begin
                if (mIsWrite) begin
                    mBusy = 0;
                    newRsp = 1;
                end else begin
                    mDataPhase = 1;
                end
            end
        end else if (mBusy) begin
            if (mIsPoll) begin
                newChange = (avm_gpio_readdata != mPollData);
                mPollData = avm_gpio_readdata;
            end else begin
                mRdata = avm_gpio_readdata;
                newRsp = 1;
            end
            mBusy = 0;
        end else if (mReadyEn) begin
            if (coe_cmd_valid) begin
                mBusy = 1; mIsWrite = coe_cmd_write; mIsPoll = 0; mDataPhase = 0;
                mAddr = coe_cmd_address;
                if (coe_cmd_write) mWdata = coe_cmd_wdata;
                if (POLL_ON && mIdleCnt < PERIOD - 1) mIdleCnt++;
            end else if (POLL_ON && mIdleCnt == PERIOD - 1) begin
                mBusy = 1; mIsWrite = 0; mIsPoll = 1; mDataPhase = 0;
                mAddr = 3'd2;
                mIdleCnt = 0;
            end else if (POLL_ON) begin
                mIdleCnt++;
            end
        end
        mReadyEn = 1;
        mRsp = newRsp;
        mChange = newChange;
    endtask

    task automatic compareAll();
        logic expWrite;
        logic expRead;
        expWrite = mBusy && !mDataPhase && mIsWrite;
        expRead  = mBusy && !mDataPhase && !mIsWrite;
        checkBit("cmd_ready", coe_cmd_ready, mReadyEn && !mBusy);
        checkBit("gpio_write", avm_gpio_write, expWrite);
        checkBit("gpio_read", avm_gpio_read, expRead);
        checkOutput("byteenable", {28'd0, avm_gpio_byteenable}, (expWrite || expRead) ? 32'hF : 32'h0);
        checkBit("rsp_valid", coe_rsp_valid, mRsp);
        checkOutput("rsp_rdata", coe_rsp_rdata, mRdata);
        checkOutput("poll_data", coe_poll_data, mPollData);
        checkBit("poll_change", coe_poll_change, mChange);
        if (expWrite || expRead) checkOutput("gpio_address", {29'd0, avm_gpio_address}, {29'd0, mAddr});
        if (expWrite) checkOutput("gpio_writedata", avm_gpio_writedata, mWdata);
    endtask

    // Model advances on each edge (or reset assertion); DUT is compared 1 time unit later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else modelStep();
        #1;
        compareAll();
    end

    int readCycles, rspPulses, pollReads, changes, firstRead;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        checkBit("rst_ready", coe_cmd_ready, 1'b0);
        checkBit("rst_write", avm_gpio_write, 1'b0);
        checkBit("rst_read", avm_gpio_read, 1'b0);
        checkBit("rst_rsp_valid", coe_rsp_valid, 1'b0);
        checkOutput("rst_address", {29'd0, avm_gpio_address}, 32'd0);
        checkOutput("rst_byteenable", {28'd0, avm_gpio_byteenable}, 32'd0);
        checkOutput("rst_poll_data", coe_poll_data, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        checkBit("ready_after_release", coe_cmd_ready, 1'b1);

        // Single write, no stall.
        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_00FF, 1'b0, 32'd0);
        @(negedge clk);
        checkBit("wr_strobe", avm_gpio_write, 1'b1);
        checkOutput("wr_address", {29'd0, avm_gpio_address}, 32'd4);
        checkOutput("wr_byteenable", {28'd0, avm_gpio_byteenable}, 32'hF);
        checkOutput("wr_data", avm_gpio_writedata, 32'h0000_00FF);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        checkBit("wr_strobe_done", avm_gpio_write, 1'b0);
        checkBit("wr_rsp", coe_rsp_valid, 1'b1);
        checkBit("wr_rsp_ready", coe_cmd_ready, 1'b1);
        @(negedge clk);
        checkBit("wr_rsp_one_cycle", coe_rsp_valid, 1'b0);

        // Read stalled for three cycles.
        applyStimulus(1'b1, 1'b0, 3'd2, 32'd0, 1'b1, 32'hA5A5_0001);
        readCycles = 0;
        rspPulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            coe_cmd_valid = 1'b0;
            if (avm_gpio_read) begin
                readCycles++;
                avm_gpio_waitrequest = (readCycles < 4);
            end else begin
                avm_gpio_waitrequest = 1'b0;
            end
            if (coe_rsp_valid) rspPulses++;
        end
        checkOutput("rd_cycles", readCycles, 32'd4);
        checkOutput("rd_rsp_pulses", rspPulses, 32'd1);
        checkOutput("rd_rdata", coe_rsp_rdata, 32'hA5A5_0001);

        // Reset in the middle of a stalled read.
        applyStimulus(1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 32'h1111_2222);
        @(negedge clk);
        checkBit("rr_read_before", avm_gpio_read, 1'b1);
        coe_cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkBit("rr_read_dropped", avm_gpio_read, 1'b0);
        checkBit("rr_ready_low", coe_cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        avm_gpio_waitrequest = 1'b0;
        rspPulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (coe_rsp_valid) rspPulses++;
        end
        checkOutput("rr_no_rsp", rspPulses, 32'd0);

`ifdef PIO_MASTER_POLL_EN
        // Two polls of an unchanging pin value: only the first reports a change.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'h1);
        pollReads = 0; changes = 0; rspPulses = 0; firstRead = -1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (avm_gpio_read) begin
                pollReads++;
                if (firstRead < 0) firstRead = i;
                checkOutput("poll_address", {29'd0, avm_gpio_address}, 32'd2);
            end
            if (coe_poll_change) changes++;
            if (coe_rsp_valid) rspPulses++;
        end
        checkOutput("poll_first_cycle", firstRead, 32'd8);
        checkOutput("poll_reads", pollReads, 32'd2);
        checkOutput("poll_changes", changes, 32'd1);
        checkOutput("poll_no_rsp", rspPulses, 32'd0);
        checkOutput("poll_value", coe_poll_data, 32'h1);

        // Command offered in the terminal-count cycle goes first, poll follows.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        checkBit("tc_ready", coe_cmd_ready, 1'b1);
        checkBit("tc_no_read", avm_gpio_read, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd5, 32'h1234, 1'b0, 32'h1);
        @(negedge clk);
        checkBit("tc_write_first", avm_gpio_write, 1'b1);
        checkBit("tc_write_no_read", avm_gpio_read, 1'b0);
        coe_cmd_valid = 1'b0;
        @(negedge clk);
        checkBit("tc_rsp", coe_rsp_valid, 1'b1);
        checkBit("tc_idle_no_read", avm_gpio_read, 1'b0);
        @(negedge clk);
        checkBit("tc_poll_read", avm_gpio_read, 1'b1);
        checkOutput("tc_poll_address", {29'd0, avm_gpio_address}, 32'd2);
`endif

        // Randomized traffic with random stalls, pin values and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1,
                          3'($urandom_range(0, 7)),
                          $urandom,
                          $urandom_range(0, 2) == 0,
                          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1)) : $urandom);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
